// File: rtl/led_scan_monitor_if.sv
// Scan bus (col/row) plus the frame stream and status of led_scan_monitor.
// The height signal exists only when LED_SCAN_HEIGHT_EN is defined.
interface led_scan_monitor_if;
  logic [7:0]  col;
  logic [7:0]  row;
  logic [63:0] frame;
  logic        frame_vld;
  logic        frame_rdy;
  logic [6:0]  lit_count;
  logic        overflow;
  logic        scan_stall;
  logic        row_err;
`ifdef LED_SCAN_HEIGHT_EN
  logic [3:0]  height;
`endif

  // master: scan controller plus frame consumer; slave: the monitor itself
`ifdef LED_SCAN_HEIGHT_EN
  modport master (output col, row, frame_rdy,
                  input  frame, frame_vld, lit_count, overflow, scan_stall, row_err, height);
  modport slave  (input  col, row, frame_rdy,
                  output frame, frame_vld, lit_count, overflow, scan_stall, row_err, height);
`else
  modport master (output col, row, frame_rdy,
                  input  frame, frame_vld, lit_count, overflow, scan_stall, row_err);
  modport slave  (input  col, row, frame_rdy,
                  output frame, frame_vld, lit_count, overflow, scan_stall, row_err);
`endif
endinterface

// File: rtl/led_scan_monitor.sv
// Receive-side decoder for the 8x8 col/row scan bus: settles each row dwell, rebuilds the frame
// and offers it on a valid/ready slot with a lit-pixel count. Optional height output: LED_SCAN_HEIGHT_EN.
module led_scan_monitor #(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 20000,
  parameter bit          ROW_ACTIVE_HIGH = 1'b1,
  parameter bit          COL_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  led_scan_monitor_if.slave bus
);
  localparam int unsigned       CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned       IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_N = CNT_W'(SETTLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_HELD} state_t;

  logic [7:0]        col_q1, col_q2, row_q1, row_q2;
  logic [7:0]        rs, cs, prev_rs, prev_cs;
  logic              one_hot, multi_hot, same;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              capture, row_err_d;
  logic [2:0]        cap_idx;
  logic [7:0][7:0]   work_q;
  logic [7:0]        seen_q, seen_d;
  logic [IDLE_W-1:0] idle_q;
  logic              timeout, frame_done, handshake, load_frame;
  logic [63:0]       frame_q;
  logic [6:0]        lit_q;
  logic              frame_vld_q, overflow_q, stall_q, row_err_q;

  function automatic logic [2:0] row_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic [6:0] popcount(input logic [63:0] img);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 7'(img[i]);
    return n;
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of the others regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q1  <= '0;
      col_q2  <= '0;
      row_q1  <= '0;
      row_q2  <= '0;
      prev_rs <= '0;
      prev_cs <= '0;
    end else begin
      col_q1  <= bus.col;
      col_q2  <= col_q1;
      row_q1  <= bus.row;
      row_q2  <= row_q1;
      prev_rs <= rs;
      prev_cs <= cs;
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    rs        = ROW_ACTIVE_HIGH ? row_q2 : ~row_q2;
    cs        = COL_ACTIVE_LOW  ? ~col_q2 : col_q2;
    multi_hot = |(rs & (rs - 8'd1));
    one_hot   = (rs != 8'd0) && !multi_hot;
    same      = (rs == prev_rs) && (cs == prev_cs);
    cap_idx   = row_index(rs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    row_err_d = 1'b0;
    if (multi_hot) begin
      // Ghosting or a bus fault: flag only the first cycle of each new multi-hot pattern.
      state_d   = ST_WAIT;
      cnt_d     = '0;
      row_err_d = (rs != prev_rs);
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (one_hot) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!same) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q >= SETTLE_N) begin
            capture = 1'b1;
            state_d = ST_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!same) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    frame_done = (seen_q == 8'hFF);
    handshake  = frame_vld_q & bus.frame_rdy;
    load_frame = frame_done && (!frame_vld_q || handshake);
    timeout    = !capture && (idle_q == IDLE_MAX - IDLE_W'(1));
    seen_d     = seen_q;
    if (frame_done || timeout) seen_d = '0;
    if (capture) seen_d[cap_idx] = 1'b1;
  end

  // NOTE: the work buffer is a small flop array, so it is cleared by reset like any
  // other state; a stale row must never leak into the first frame after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q      <= '0;
      seen_q      <= '0;
      idle_q      <= '0;
      stall_q     <= 1'b0;
      row_err_q   <= 1'b0;
      frame_q     <= '0;
      lit_q       <= '0;
      frame_vld_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      seen_q    <= seen_d;
      row_err_q <= row_err_d;
      if (capture) begin
        work_q[cap_idx] <= cs;
        idle_q          <= '0;
        stall_q         <= 1'b0;
      end else if (idle_q != IDLE_MAX) begin
        idle_q <= idle_q + IDLE_W'(1);
        if (timeout) stall_q <= 1'b1;
      end
      if (load_frame) begin
        frame_q     <= work_q;
        lit_q       <= popcount(work_q);
        frame_vld_q <= 1'b1;
      end else if (frame_done) begin
        overflow_q  <= 1'b1;
      end else if (handshake) begin
        frame_vld_q <= 1'b0;
      end
    end
  end

  assign bus.frame      = frame_q;
  assign bus.lit_count  = lit_q;
  assign bus.frame_vld  = frame_vld_q;
  assign bus.overflow   = overflow_q;
  assign bus.scan_stall = stall_q;
  assign bus.row_err    = row_err_q;

`ifdef LED_SCAN_HEIGHT_EN
  // Height follows the free-fall convention: 1 + highest lit row, 0 for a blank frame.
  function automatic logic [3:0] top_lit_row(input logic [63:0] img);
    logic [3:0] h;
    h = '0;
    for (int r = 0; r < 8; r++) if (|img[8*r +: 8]) h = 4'(r + 1);
    return h;
  endfunction

  logic [3:0] height_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          height_q <= '0;
    else if (load_frame) height_q <= top_lit_row(work_q);
  end

  assign bus.height = height_q;
`endif
endmodule

// File: tb/tb_led_scan_monitor.sv
// Directed self-checking bench for led_scan_monitor (default parameters, 20 MHz clock).
// Height checks are compiled in when LED_SCAN_HEIGHT_EN is defined.
module tb_led_scan_monitor;
  logic clk = 1'b0;
  logic rst_n;

  always #25 clk = ~clk;

  led_scan_monitor_if bus();

  led_scan_monitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [63:0] IMG_A = 64'h8181_8181_8181_8181;
  localparam logic [63:0] IMG_B = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IMG_C = 64'h0000_0000_0004_0201;

  int          n_checks   = 0;
  int          n_fails    = 0;
  int          hs_count   = 0;
  int          err_count  = 0;
  logic [63:0] last_frame = '0;
  logic [6:0]  last_lit   = '0;

  // Records every completed handshake and every row_err cycle.
  always @(posedge clk) begin
    if (bus.frame_vld === 1'b1 && bus.frame_rdy === 1'b1) begin
      hs_count   <= hs_count + 1;
      last_frame <= bus.frame;
      last_lit   <= bus.lit_count;
    end
    if (bus.row_err === 1'b1) err_count <= err_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two blank cycles, then one row held for `dwell` cycles with active-low column drive.
  task automatic drive_row(input int r, input logic [7:0] lit, input int dwell);
    bus.row = 8'h00;
    tick(2);
    bus.row = 8'(1 << r);
    bus.col = ~lit;
    tick(dwell);
  endtask

  task automatic scan(input logic [63:0] img, input int first, input int last, input int dwell);
    for (int r = first; r <= last; r++) drive_row(r, img[8*r +: 8], dwell);
    bus.row = 8'h00;
  endtask

  int e0;

  initial begin
    rst_n         = 1'b0;
    bus.row       = 8'h00;
    bus.col       = 8'hFF;
    bus.frame_rdy = 1'b0;
    tick(3);
    check("rst_frame",     bus.frame,      64'h0);
    check("rst_vld",       bus.frame_vld,  64'h0);
    check("rst_lit",       bus.lit_count,  64'h0);
    check("rst_overflow",  bus.overflow,   64'h0);
    check("rst_stall",     bus.scan_stall, 64'h0);
    check("rst_row_err",   bus.row_err,    64'h0);
`ifdef LED_SCAN_HEIGHT_EN
    check("rst_height",    bus.height,     64'h0);
`endif
    rst_n = 1'b1;
    tick(2);

    // 1: reset in the middle of a frame discards the captured rows
    bus.frame_rdy = 1'b1;
    scan(IMG_A, 0, 3, 10);
    rst_n = 1'b0;
    #2;
    check("t1_mid_rst_vld",      bus.frame_vld, 64'h0);
    check("t1_mid_rst_lit",      bus.lit_count, 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    scan(IMG_A, 4, 7, 10);
    tick(10);
    check("t1_partial_no_frame", 64'(hs_count), 64'd0);
    scan(IMG_A, 0, 3, 10);
    tick(10);
    check("t1_one_frame",        64'(hs_count), 64'd1);
    check("t1_frame",            last_frame,    IMG_A);
    check("t1_lit",              64'(last_lit), 64'd16);

    // 2: clean scan, exact frame_vld latency after the row-7 capture
    bus.frame_rdy = 1'b0;
    scan(IMG_A, 0, 6, 10);
    bus.row = 8'h00;
    tick(2);
    bus.row = 8'h80;
    bus.col = ~8'h81;
    tick(7);
    check("t2_vld_not_yet",  bus.frame_vld, 64'h0);
    tick(1);
    check("t2_vld_rise",     bus.frame_vld, 64'h1);
    check("t2_frame",        bus.frame,     IMG_A);
    check("t2_lit",          bus.lit_count, 64'd16);
`ifdef LED_SCAN_HEIGHT_EN
    check("t2_height",       bus.height,    64'd8);
`endif
    tick(5);
    check("t2_vld_held",     bus.frame_vld, 64'h1);
    check("t2_frame_held",   bus.frame,     IMG_A);
    check("t2_no_overflow",  bus.overflow,  64'h0);
    bus.frame_rdy = 1'b1;
    tick(1);
    check("t2_vld_drop",     bus.frame_vld, 64'h0);
    check("t2_hs_count",     64'(hs_count), 64'd2);
    bus.row = 8'h00;

    // 3: short dwells never capture; timeout discards the partial frame
    scan(IMG_A, 0, 3, 10);
    scan(IMG_A, 4, 7, 3);
    tick(10);
    check("t3_short_no_frame",   64'(hs_count),  64'd2);
    tick(19000);
    check("t3_stall_before",     bus.scan_stall, 64'h0);
    tick(1000);
    check("t3_stall_after",      bus.scan_stall, 64'h1);
    check("t3_no_frame_stalled", 64'(hs_count),  64'd2);
    scan(IMG_A, 4, 4, 10);
    check("t3_stall_cleared",    bus.scan_stall, 64'h0);
    scan(IMG_A, 5, 7, 10);
    tick(10);
    check("t3_seen_discarded",   64'(hs_count),  64'd2);
    scan(IMG_A, 0, 3, 10);
    tick(5);
    check("t3_frame_after",      64'(hs_count),  64'd3);

    // 4: backpressure across two scans
    bus.frame_rdy = 1'b0;
    scan(IMG_B, 0, 7, 10);
    tick(3);
    check("t4_vld",            bus.frame_vld, 64'h1);
    check("t4_frame",          bus.frame,     IMG_B);
    check("t4_lit",            bus.lit_count, 64'd32);
    check("t4_overflow_clear", bus.overflow,  64'h0);
    scan(64'hFFFF_FFFF_FFFF_FFFF, 0, 7, 10);
    tick(3);
    check("t4_overflow_set",   bus.overflow,  64'h1);
    check("t4_vld_held",       bus.frame_vld, 64'h1);
    check("t4_frame_held",     bus.frame,     IMG_B);
    check("t4_lit_held",       bus.lit_count, 64'd32);
`ifdef LED_SCAN_HEIGHT_EN
    check("t4_height_held",    bus.height,    64'd8);
`endif
    bus.frame_rdy = 1'b1;
    tick(1);
    check("t4_vld_drop",       bus.frame_vld, 64'h0);
    check("t4_hs_count",       64'(hs_count), 64'd4);
    bus.frame_rdy = 1'b0;
    tick(1);
    check("t4_overflow_sticky", bus.overflow, 64'h1);

    // 5: multi-hot glitch flags once and captures nothing
    e0      = err_count;
    bus.col = ~8'h81;
    bus.row = 8'h03;
    tick(5);
    bus.row = 8'h00;
    tick(3);
    check("t5_row_err_once",  64'(err_count - e0), 64'd1);
    check("t5_row_err_low",   bus.row_err,         64'h0);
    scan(IMG_C, 1, 7, 10);
    tick(5);
    check("t5_no_capture",    bus.frame_vld,       64'h0);
    scan(IMG_C, 0, 0, 10);
    tick(3);
    check("t5_vld",           bus.frame_vld,       64'h1);
    check("t5_frame",         bus.frame,           IMG_C);
    check("t5_lit",           bus.lit_count,       64'd3);
`ifdef LED_SCAN_HEIGHT_EN
    check("t5_height",        bus.height,          64'd3);
`endif
    bus.frame_rdy = 1'b1;
    tick(1);
    check("t5_vld_drop",      bus.frame_vld,       64'h0);
    bus.frame_rdy = 1'b0;

    // 6: blank frame
    scan(64'h0, 0, 7, 10);
    tick(3);
    check("t6_vld",    bus.frame_vld, 64'h1);
    check("t6_frame",  bus.frame,     64'h0);
    check("t6_lit",    bus.lit_count, 64'd0);
`ifdef LED_SCAN_HEIGHT_EN
    check("t6_height", bus.height,    64'd0);
`endif
    bus.frame_rdy = 1'b1;
    tick(1);
    check("t6_vld_drop", bus.frame_vld, 64'h0);
    check("t6_hs_count", 64'(hs_count), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
